// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin share of one UART TX core among three message sources;
//            latches a 1..MAX_BYTES message and streams it byte by byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int MAX_BYTES  = 4,
    parameter int TX_TIMEOUT = 200000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               req,
    input  logic [3*8*MAX_BYTES-1:0] msg_flat,
    input  logic [8:0]               len_flat,
    output logic [2:0]               ack,
    output logic [2:0]               done,
    output logic [2:0]               err,
    output logic                     busy,
    output logic                     tx_dv,
    output logic [7:0]               tx_byte,
    input  logic                     tx_ready,
    input  logic                     tx_done
);

    localparam int             MSG_W      = 8 * MAX_BYTES;
    localparam int             TW         = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TX_TIMEOUT - 1);
    localparam logic [2:0]     MAX_LEN    = 3'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         rr, rr_nxt;
    logic [1:0]         owner, owner_nxt;
    logic [MSG_W-1:0]   shift, shift_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [2:0]         ack_nxt, done_nxt, err_nxt;
    logic               dv_nxt;
    logic [7:0]         byte_nxt;

    logic [1:0]         cand [3];
    logic               gnt_valid;
    logic [1:0]         gnt;
    logic [1:0]         rr_after;
    logic [MSG_W-1:0]   gnt_msg;
    logic [2:0]         gnt_len_raw;
    logic [2:0]         gnt_len;

    // Search order starts at rr so the last winner is always checked last.
    always_comb begin
        cand[0]   = rr;
        cand[1]   = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
        cand[2]   = (rr == 2'd0) ? 2'd2 : rr - 2'd1;
        gnt_valid = 1'b0;
        gnt       = rr;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_valid && req[cand[k]]) begin
                gnt_valid = 1'b1;
                gnt       = cand[k];
            end
        end
        rr_after    = (gnt == 2'd2) ? 2'd0 : gnt + 2'd1;
        gnt_msg     = msg_flat[int'(gnt)*MSG_W +: MSG_W];
        gnt_len_raw = len_flat[int'(gnt)*3 +: 3];
        gnt_len     = (gnt_len_raw > MAX_LEN) ? MAX_LEN : gnt_len_raw;
    end

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        owner_nxt = owner;
        shift_nxt = shift;
        cnt_nxt   = cnt;
        timer_nxt = timer;
        ack_nxt   = 3'b000;
        done_nxt  = 3'b000;
        err_nxt   = 3'b000;
        dv_nxt    = 1'b0;
        byte_nxt  = tx_byte;
        case (state)
            S_IDLE: begin
                if (gnt_valid) begin
                    ack_nxt   = 3'b001 << gnt;
                    shift_nxt = gnt_msg;
                    cnt_nxt   = gnt_len;
                    owner_nxt = gnt;
                    rr_nxt    = rr_after;
                    state_nxt = (gnt_len == 3'd0) ? S_FIN : S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    dv_nxt    = 1'b1;
                    byte_nxt  = shift[7:0];
                    shift_nxt = shift >> 8;
                    cnt_nxt   = cnt - 3'd1;
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                timer_nxt = timer + TW'(1);
                // tx_done takes priority over a coincident timeout.
                if (tx_done) begin
                    state_nxt = (cnt == 3'd0) ? S_FIN : S_SEND;
                end else if (timer == TIMER_LAST) begin
                    err_nxt   = 3'b001 << owner;
                    shift_nxt = '0;
                    cnt_nxt   = 3'd0;
                    state_nxt = S_IDLE;
                end
            end
            S_FIN: begin
                done_nxt  = 3'b001 << owner;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            rr      <= 2'd0;
            owner   <= 2'd0;
            shift   <= '0;
            cnt     <= 3'd0;
            timer   <= '0;
            ack     <= 3'b000;
            done    <= 3'b000;
            err     <= 3'b000;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            state   <= state_nxt;
            rr      <= rr_nxt;
            owner   <= owner_nxt;
            shift   <= shift_nxt;
            cnt     <= cnt_nxt;
            timer   <= timer_nxt;
            ack     <= ack_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            tx_dv   <= dv_nxt;
            tx_byte <= byte_nxt;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a behavioural TX core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int EV_ACK  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_DV   = 3;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [95:0] msg_flat;
    logic [8:0]  len_flat;
    logic [2:0]  ack, done, err;
    logic        busy, tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_ready, tx_done;

    logic        model_ready;
    logic        hold_ready;
    logic        withhold;
    int          tx_delay;
    bit          tx_active;
    int          mcnt;
    int          cyc;
    int          txdone_cyc;
    int          dv_count;
    int          done_count;
    int          n_checks;
    int          n_errors;

    logic [7:0]  exp_bytes [$];
    logic [2:0]  exp_ack   [$];
    logic [2:0]  exp_done  [$];
    logic [2:0]  exp_err   [$];

    assign tx_ready = model_ready && !hold_ready;

    uart_tx_arbiter #(.MAX_BYTES(4), .TX_TIMEOUT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .msg_flat (msg_flat),
        .len_flat (len_flat),
        .ack      (ack),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .tx_ready (tx_ready),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // TX core model: accepts a byte on tx_dv, pulses tx_done tx_delay+1 cycles later.
    initial begin
        model_ready = 1'b1;
        tx_done     = 1'b0;
        tx_active   = 0;
        mcnt        = 0;
        txdone_cyc  = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (!reset) begin
                tx_active = 0;
            end else if (tx_active) begin
                if (!withhold) begin
                    if (mcnt == 0) begin
                        tx_done    = 1'b1;
                        tx_active  = 0;
                        txdone_cyc = cyc;
                    end else begin
                        mcnt--;
                    end
                end
            end else if (tx_dv) begin
                tx_active = 1;
                mcnt      = tx_delay;
            end
            model_ready = !tx_active;
        end
    end

    // Output monitor: every observed pulse is matched against the scoreboard.
    initial begin
        dv_count   = 0;
        done_count = 0;
        forever begin
            @(negedge clk);
            if (tx_dv) begin
                dv_count++;
                if (exp_bytes.size() > 0) check("tx_byte", tx_byte, exp_bytes.pop_front());
                else                      check("tx_extra", 1, 0);
                check("dv_with_ack", ack, 3'b000);
            end
            if (|ack) begin
                if (exp_ack.size() > 0) check("ack", ack, exp_ack.pop_front());
                else                    check("ack_extra", ack, 3'b000);
            end
            if (|done) begin
                done_count++;
                if (exp_done.size() > 0) check("done", done, exp_done.pop_front());
                else                     check("done_extra", done, 3'b000);
            end
            if (|err) begin
                if (exp_err.size() > 0) check("err", err, exp_err.pop_front());
                else                    check("err_extra", err, 3'b000);
            end
        end
    end

    task automatic set_client(input int i, input logic [31:0] msg, input logic [2:0] len);
        msg_flat[i*32 +: 32] = msg;
        len_flat[i*3 +: 3]   = len;
    endtask

    task automatic wait_evt(input int sel, input int max_cyc, input string tag, output int at_cyc);
        bit hit;
        hit    = 0;
        at_cyc = -1;
        for (int i = 0; i < max_cyc && !hit; i++) begin
            @(negedge clk);
            case (sel)
                EV_ACK:  hit = |ack;
                EV_DONE: hit = |done;
                EV_ERR:  hit = |err;
                default: hit = tx_dv;
            endcase
            if (hit) at_cyc = cyc;
        end
        if (!hit) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit idle;
        idle = 0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
        end
        if (!idle) check({tag, "_idle_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a, v, v2, dn, e, d, r, dn0;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        req        = 3'b000;
        msg_flat   = '0;
        len_flat   = '0;
        hold_ready = 1'b0;
        withhold   = 1'b0;
        tx_delay   = 3;

        repeat (2) @(negedge clk);
        check("rst_ack", ack, 3'b000);
        check("rst_done", done, 3'b000);
        check("rst_err", err, 3'b000);
        check("rst_dv", tx_dv, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_byte", tx_byte, 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;

        // Two-byte message from client 0
        set_client(0, 32'h0000_3532, 3'd2);
        exp_ack.push_back(3'b001);
        exp_bytes.push_back(8'h32);
        exp_bytes.push_back(8'h35);
        exp_done.push_back(3'b001);
        @(posedge clk);
        #1 d = cyc;
        req = 3'b001;
        wait_evt(EV_ACK, 10, "t1_ack", a);
        req = 3'b000;
        check("t1_ack_lat", a - d, 1);
        wait_evt(EV_DV, 10, "t1_dv1", v);
        check("t1_dv1_lat", v - a, 1);
        wait_evt(EV_DV, 20, "t1_dv2", v2);
        check("t1_dv2_gap", v2 - txdone_cyc, 2);
        wait_evt(EV_DONE, 20, "t1_done", dn);
        check("t1_done_lat", dn - txdone_cyc, 2);
        @(negedge clk);
        check("t1_busy_after", busy, 1'b0);

        // Round robin with all three requesting continuously
        do_reset();
        set_client(0, 32'h41, 3'd1);
        set_client(1, 32'h42, 3'd1);
        set_client(2, 32'h43, 3'd1);
        foreach (exp_ack[i]) check("t2_sb_clean", 1, 0);
        exp_ack   = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_bytes = '{8'h41, 8'h42, 8'h43, 8'h41};
        exp_done  = '{3'b001, 3'b010, 3'b100, 3'b001};
        d = dv_count;
        @(posedge clk);
        #1 req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_evt(EV_ACK, 50, "t2_ack", a);
            if (k == 3) req = 3'b000;
        end
        wait_idle(100, "t2");
        check("t2_dv_count", dv_count - d, 4);

        // Empty message: ack then done, no byte
        set_client(1, 32'h0, 3'd0);
        exp_ack.push_back(3'b010);
        exp_done.push_back(3'b010);
        d = dv_count;
        @(posedge clk);
        #1 req = 3'b010;
        wait_evt(EV_ACK, 10, "t3_ack", a);
        req = 3'b000;
        wait_evt(EV_DONE, 10, "t3_done", dn);
        check("t3_done_lat", dn - a, 1);
        wait_idle(20, "t3");
        check("t3_no_dv", dv_count - d, 0);

        // TX core not ready for 50 cycles after grant
        set_client(2, 32'h77, 3'd1);
        exp_ack.push_back(3'b100);
        exp_bytes.push_back(8'h77);
        exp_done.push_back(3'b100);
        hold_ready = 1'b1;
        @(posedge clk);
        #1 req = 3'b100;
        wait_evt(EV_ACK, 10, "t4_ack", a);
        req = 3'b000;
        d = dv_count;
        repeat (50) @(negedge clk);
        check("t4_no_dv", dv_count - d, 0);
        check("t4_busy", busy, 1'b1);
        @(posedge clk);
        #1 hold_ready = 1'b0;
        r = cyc;
        wait_evt(EV_DV, 10, "t4_dv", v);
        check("t4_dv_lat", v - r, 1);
        wait_idle(30, "t4");

        // Timeout on client 0, client 1 served afterwards
        withhold = 1'b1;
        set_client(0, 32'h0000_AA55, 3'd2);
        set_client(1, 32'h66, 3'd1);
        exp_ack.push_back(3'b001);
        exp_ack.push_back(3'b010);
        exp_bytes.push_back(8'h55);
        exp_bytes.push_back(8'h66);
        exp_err.push_back(3'b001);
        exp_done.push_back(3'b010);
        dn0 = done_count;
        @(posedge clk);
        #1 req = 3'b011;
        wait_evt(EV_ACK, 10, "t5_ack0", a);
        req = 3'b010;
        wait_evt(EV_DV, 10, "t5_dv", v);
        wait_evt(EV_ERR, 40, "t5_err", e);
        check("t5_err_lat", e - v, 16);
        check("t5_no_done", done_count - dn0, 0);
        withhold = 1'b0;
        wait_evt(EV_ACK, 10, "t5_ack1", a);
        req = 3'b000;
        wait_idle(50, "t5");

        // Reset in the middle of a four-byte message
        tx_delay = 6;
        set_client(0, 32'h4433_2211, 3'd4);
        exp_ack.push_back(3'b001);
        exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h22);
        @(posedge clk);
        #1 req = 3'b001;
        wait_evt(EV_ACK, 10, "t6_ack", a);
        req = 3'b000;
        wait_evt(EV_DV, 10, "t6_dv1", v);
        wait_evt(EV_DV, 20, "t6_dv2", v);
        repeat (2) @(posedge clk);
        #1 check("t6_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_rst_ack", ack, 3'b000);
        check("t6_rst_done", done, 3'b000);
        check("t6_rst_err", err, 3'b000);
        check("t6_rst_dv", tx_dv, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_byte", tx_byte, 8'h00);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tx_delay = 3;
        // rr was 1 before reset; a cleared pointer grants client 0 ahead of 2
        set_client(0, 32'h5A, 3'd1);
        set_client(2, 32'hC3, 3'd1);
        exp_ack.push_back(3'b001);
        exp_ack.push_back(3'b100);
        exp_bytes.push_back(8'h5A);
        exp_bytes.push_back(8'hC3);
        exp_done.push_back(3'b001);
        exp_done.push_back(3'b100);
        req = 3'b101;
        wait_evt(EV_ACK, 10, "t6_ack0", a);
        req = 3'b100;
        wait_evt(EV_ACK, 30, "t6_ack2", a);
        req = 3'b000;
        wait_idle(50, "t6");

        check("sb_empty", exp_bytes.size() + exp_ack.size() + exp_done.size() + exp_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
